// File: rtl/mackerel_bus_controller.sv
// Mackerel system controller: 68000 address decode, wait-state DTACK/VPA, bus-error
// watchdog, interrupt priority encoder, CPU clock divider and write-only GPIO ports.
module mackerel_bus_controller #(
  parameter int CLK_DIV      = 2,
  parameter int ROM_WAIT     = 1,
  parameter int RAM_WAIT     = 0,
  parameter int IO_WAIT      = 2,
  parameter int BERR_TIMEOUT = 64,
  parameter int GPIO_PORTS   = 2,
  parameter int DUART_LEVEL  = 5,
  parameter int EXP_LEVEL    = 3
) (
  input  logic                    CLK,
  input  logic                    RST,
  output logic                    CLK_CPU,
  input  logic [3:0]              ADDR_H,
  input  logic [3:0]              ADDR_L,
  input  logic [7:0]              DATA,
  input  logic                    AS,
  input  logic                    UDS,
  input  logic                    LDS,
  input  logic                    RW,
  input  logic [2:0]              FC,
  input  logic                    IRQ_DUART_N,
  input  logic                    IRQ_EXP_N,
  output logic                    ROM_LOWER,
  output logic                    ROM_UPPER,
  output logic                    RAM_LOWER,
  output logic                    RAM_UPPER,
  output logic                    DUART_CS,
  output logic                    IACK_DUART,
  output logic                    DTACK,
  output logic                    BERR,
  output logic                    VPA,
  output logic [2:0]              IPL,
  output logic [2:0]              LED,
  output logic [8*GPIO_PORTS-1:0] GPIO
);

  localparam int DIV_HALF = CLK_DIV / 2;
  localparam int DIV_W    = $clog2(DIV_HALF - 1) + 1;
  localparam int CNT_W    = $clog2(BERR_TIMEOUT - 1) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV_HALF - 1);
  localparam logic [CNT_W-1:0] ROM_LOAD  = CNT_W'(ROM_WAIT);
  localparam logic [CNT_W-1:0] RAM_LOAD  = CNT_W'(RAM_WAIT);
  localparam logic [CNT_W-1:0] IO_LOAD   = CNT_W'(IO_WAIT);
  localparam logic [CNT_W-1:0] BERR_LOAD = CNT_W'(BERR_TIMEOUT - 1);
  localparam logic [2:0]       DUART_LVL = 3'(DUART_LEVEL);
  localparam logic [2:0]       EXP_LVL   = 3'(EXP_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             clk_cpu_q, clk_cpu_d;
  logic             as_prev_q, as_prev_d;
  logic             err_q, err_d;
  logic             avec_q, avec_d;
  logic             ctrl_q, ctrl_d;
  logic             dtack_q, dtack_d;
  logic             berr_q, berr_d;
  logic             vpa_q, vpa_d;
  logic [2:0]       ipl_q, ipl_d;
  logic [2:0]       led_q, led_d;
  logic [8*GPIO_PORTS-1:0] gpio_q, gpio_d;

  logic             iack_s, rom_s, ram_s, duart_s, ctrl_s, mapped_s;
  logic             iack_duart_lvl_s;
  logic [CNT_W-1:0] wait_load_s;
  logic [2:0]       irq_level_s;
  logic             ctrl_wr_s;

  // An IACK cycle owns the bus whatever address the CPU drives.
  assign iack_s           = (FC == 3'b111);
  assign rom_s            = ~iack_s & (ADDR_H == 4'h0);
  assign ram_s            = ~iack_s & (ADDR_H == 4'h8);
  assign duart_s          = ~iack_s & (ADDR_H == 4'hC);
  assign ctrl_s           = ~iack_s & (ADDR_H == 4'hF);
  assign mapped_s         = rom_s | ram_s | duart_s | ctrl_s | iack_s;
  assign iack_duart_lvl_s = (ADDR_L[2:0] == DUART_LVL);

  assign ROM_LOWER  = ~(~AS & ~LDS & rom_s);
  assign ROM_UPPER  = ~(~AS & ~UDS & rom_s);
  assign RAM_LOWER  = ~(~AS & ~LDS & ram_s);
  assign RAM_UPPER  = ~(~AS & ~UDS & ram_s);
  assign DUART_CS   = ~(~AS & ~LDS & duart_s);
  assign IACK_DUART = ~(~AS & iack_s & iack_duart_lvl_s);

  assign CLK_CPU = clk_cpu_q;
  assign DTACK   = dtack_q;
  assign BERR    = berr_q;
  assign VPA     = vpa_q;
  assign IPL     = ipl_q;
  assign LED     = led_q;
  assign GPIO    = gpio_q;

  // Wait count loaded at cycle start; unmapped cycles load the watchdog instead.
  always_comb begin
    wait_load_s = BERR_LOAD;
    if (rom_s) begin
      wait_load_s = ROM_LOAD;
    end else if (ram_s) begin
      wait_load_s = RAM_LOAD;
    end else if (duart_s | ctrl_s | iack_s) begin
      wait_load_s = IO_LOAD;
    end else begin
      wait_load_s = BERR_LOAD;
    end
  end

  // CPU clock divider and interrupt level encoder.
  always_comb begin
    div_d       = div_q;
    clk_cpu_d   = clk_cpu_q;
    irq_level_s = 3'd0;
    if (div_q == DIV_LAST) begin
      div_d     = {DIV_W{1'b0}};
      clk_cpu_d = ~clk_cpu_q;
    end else begin
      div_d     = div_q + DIV_W'(1);
      clk_cpu_d = clk_cpu_q;
    end
    if (!IRQ_DUART_N && !IRQ_EXP_N) begin
      irq_level_s = (DUART_LVL > EXP_LVL) ? DUART_LVL : EXP_LVL;
    end else if (!IRQ_DUART_N) begin
      irq_level_s = DUART_LVL;
    end else if (!IRQ_EXP_N) begin
      irq_level_s = EXP_LVL;
    end else begin
      irq_level_s = 3'd0;
    end
    ipl_d = ~irq_level_s;
  end

  // Bus-cycle FSM: next state and registered bus responses.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    avec_d    = avec_q;
    ctrl_d    = ctrl_q;
    dtack_d   = dtack_q;
    berr_d    = berr_q;
    vpa_d     = vpa_q;
    ctrl_wr_s = 1'b0;
    as_prev_d = AS;
    case (state_q)
      ST_IDLE: begin
        if (!AS && as_prev_q) begin
          state_d = ST_WAIT;
          cnt_d   = wait_load_s;
          err_d   = ~mapped_s;
          avec_d  = iack_s & ~iack_duart_lvl_s;
          ctrl_d  = ctrl_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (AS) begin
          state_d = ST_IDLE;
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          if (err_q) begin
            state_d = ST_ERR;
            berr_d  = 1'b0;
          end else begin
            state_d   = ST_ACK;
            ctrl_wr_s = ctrl_q & ~LDS & ~RW;
            if (avec_q) begin
              vpa_d = 1'b0;
            end else begin
              dtack_d = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACK, ST_ERR: begin
        if (AS) begin
          state_d = ST_IDLE;
          dtack_d = 1'b1;
          berr_d  = 1'b1;
          vpa_d   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        dtack_d = 1'b1;
        berr_d  = 1'b1;
        vpa_d   = 1'b1;
      end
    endcase
  end

  // Control register writes: offset 0 is the LED latch, offsets 1..GPIO_PORTS the ports.
  always_comb begin
    led_d  = led_q;
    gpio_d = gpio_q;
    if (ctrl_wr_s) begin
      if (ADDR_L == 4'd0) begin
        led_d = DATA[2:0];
      end else begin
        led_d = led_q;
      end
      for (int k = 0; k < GPIO_PORTS; k++) begin
        if (ADDR_L == 4'(k + 1)) begin
          gpio_d[8*k +: 8] = DATA;
        end else begin
          gpio_d[8*k +: 8] = gpio_q[8*k +: 8];
        end
      end
    end else begin
      led_d  = led_q;
      gpio_d = gpio_q;
    end
  end

  // State register; reset abandons any bus cycle in flight.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      div_q     <= {DIV_W{1'b0}};
      clk_cpu_q <= 1'b0;
      as_prev_q <= 1'b1;
      err_q     <= 1'b0;
      avec_q    <= 1'b0;
      ctrl_q    <= 1'b0;
      dtack_q   <= 1'b1;
      berr_q    <= 1'b1;
      vpa_q     <= 1'b1;
      ipl_q     <= 3'b111;
      led_q     <= 3'd0;
      gpio_q    <= {(8*GPIO_PORTS){1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      clk_cpu_q <= clk_cpu_d;
      as_prev_q <= as_prev_d;
      err_q     <= err_d;
      avec_q    <= avec_d;
      ctrl_q    <= ctrl_d;
      dtack_q   <= dtack_d;
      berr_q    <= berr_d;
      vpa_q     <= vpa_d;
      ipl_q     <= ipl_d;
      led_q     <= led_d;
      gpio_q    <= gpio_d;
    end
  end

endmodule
